// File: rtl/pdp8_dma_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_dma_arb_if
// Description : Request, completion and memory-port bundle for pdp8_dma_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdp8_dma_arb_if;
    logic        req0_read;
    logic        req0_write;
    logic [14:0] req0_ma;
    logic [11:0] req0_out;
    logic        done0;
    logic [11:0] in0;

    logic        req1_read;
    logic        req1_write;
    logic [14:0] req1_ma;
    logic [11:0] req1_out;
    logic        done1;
    logic [11:0] in1;

    logic        ram_read_req;
    logic        ram_write_req;
    logic [14:0] ram_ma;
    logic [11:0] ram_out;
    logic        ram_done;
    logic [11:0] ram_in;

    logic [1:0]  grant;
    logic        timeout;

    // Requesters plus memory controller: everything around the arbiter.
    modport master (
        output req0_read, req0_write, req0_ma, req0_out,
        output req1_read, req1_write, req1_ma, req1_out,
        output ram_done, ram_in,
        input  done0, in0, done1, in1,
        input  ram_read_req, ram_write_req, ram_ma, ram_out,
        input  grant, timeout
    );

    modport slave (
        input  req0_read, req0_write, req0_ma, req0_out,
        input  req1_read, req1_write, req1_ma, req1_out,
        input  ram_done, ram_in,
        output done0, in0, done1, in1,
        output ram_read_req, ram_write_req, ram_ma, ram_out,
        output grant, timeout
    );
endinterface
`default_nettype wire

// File: rtl/pdp8_dma_arb.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_dma_arb
// Description : Two-channel arbiter for the pdp8_io DMA memory port, with
//               round-robin or fixed priority and a memory-done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pdp8_dma_arb #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  wire            clk,
    input  wire            reset,
    pdp8_dma_arb_if.slave  bus
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_busy    = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;
    localparam logic [7:0] c_timeout    = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_BUSY    = c_st_busy,
        ST_RELEASE = c_st_release
    } state_t;

    state_t      r_state,         w_state_next;
    logic        r_last,          w_last;        // 1 = channel 1 was granted last
    logic [7:0]  r_cnt,           w_cnt;
    logic        r_is_write,      w_is_write;
    logic        r_ram_read_req,  w_ram_read_req;
    logic        r_ram_write_req, w_ram_write_req;
    logic [14:0] r_ram_ma,        w_ram_ma;
    logic [11:0] r_ram_out,       w_ram_out;
    logic [1:0]  r_grant,         w_grant;
    logic        r_done0,         w_done0;
    logic        r_done1,         w_done1;
    logic [11:0] r_in0,           w_in0;
    logic [11:0] r_in1,           w_in1;
    logic        r_timeout,       w_timeout;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick1;
    logic        w_win_write;
    logic [11:0] w_rdata;

    assign w_req0 = bus.req0_read | bus.req0_write;
    assign w_req1 = bus.req1_read | bus.req1_write;

    // On a tie, round-robin hands the port to whichever channel did not have it last.
    assign w_pick1 = (RR != 0) ? (w_req1 & (~w_req0 | ~r_last))
                               : (w_req1 & ~w_req0);
    assign w_win_write = w_pick1 ? bus.req1_write : bus.req0_write;
    assign w_rdata     = bus.ram_done ? bus.ram_in : 12'o0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_last          <= 1'b1;
            r_cnt           <= 8'd0;
            r_is_write      <= 1'b0;
            r_ram_read_req  <= 1'b0;
            r_ram_write_req <= 1'b0;
            r_ram_ma        <= 15'd0;
            r_ram_out       <= 12'd0;
            r_grant         <= 2'b00;
            r_done0         <= 1'b0;
            r_done1         <= 1'b0;
            r_in0           <= 12'd0;
            r_in1           <= 12'd0;
            r_timeout       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_last          <= w_last;
            r_cnt           <= w_cnt;
            r_is_write      <= w_is_write;
            r_ram_read_req  <= w_ram_read_req;
            r_ram_write_req <= w_ram_write_req;
            r_ram_ma        <= w_ram_ma;
            r_ram_out       <= w_ram_out;
            r_grant         <= w_grant;
            r_done0         <= w_done0;
            r_done1         <= w_done1;
            r_in0           <= w_in0;
            r_in1           <= w_in1;
            r_timeout       <= w_timeout;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_last          = r_last;
        w_cnt           = r_cnt;
        w_is_write      = r_is_write;
        w_ram_read_req  = r_ram_read_req;
        w_ram_write_req = r_ram_write_req;
        w_ram_ma        = r_ram_ma;
        w_ram_out       = r_ram_out;
        w_grant         = r_grant;
        w_done0         = 1'b0;
        w_done1         = 1'b0;
        w_in0           = r_in0;
        w_in1           = r_in1;
        w_timeout       = r_timeout;

        case (r_state)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_next    = ST_BUSY;
                    w_last          = w_pick1;
                    w_cnt           = 8'd0;
                    w_is_write      = w_win_write;
                    w_ram_write_req = w_win_write;
                    w_ram_read_req  = ~w_win_write;
                    w_ram_ma        = w_pick1 ? bus.req1_ma  : bus.req0_ma;
                    w_ram_out       = w_pick1 ? bus.req1_out : bus.req0_out;
                    w_grant         = w_pick1 ? 2'b10 : 2'b01;
                end
            end
            ST_BUSY: begin
                // A done arriving on the last allowed cycle still counts as a normal completion.
                if (bus.ram_done || (r_cnt == c_timeout)) begin
                    w_state_next    = ST_RELEASE;
                    w_ram_read_req  = 1'b0;
                    w_ram_write_req = 1'b0;
                    w_grant         = 2'b00;
                    w_done0         = r_grant[0];
                    w_done1         = r_grant[1];
                    if (!r_is_write) begin
                        if (r_grant[1]) w_in1 = w_rdata;
                        else            w_in0 = w_rdata;
                    end
                    if (!bus.ram_done) w_timeout = 1'b1;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_read_req  = r_ram_read_req;
    assign bus.ram_write_req = r_ram_write_req;
    assign bus.ram_ma        = r_ram_ma;
    assign bus.ram_out       = r_ram_out;
    assign bus.grant         = r_grant;
    assign bus.done0         = r_done0;
    assign bus.done1         = r_done1;
    assign bus.in0           = r_in0;
    assign bus.in1           = r_in1;
    assign bus.timeout       = r_timeout;

endmodule
`default_nettype wire
